// File: rtl/pc_gen_ras.sv
// pc_gen_ras: fetch PC generator with trap/mret/jump/branch selection, EPC and a circular return-address stack
module pc_gen_ras #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100,
    parameter int RAS_DEPTH = 4,
    parameter int RAS_CW = 3
) (
    input logic clk,
    input logic reset,
    input logic pc_en,
    input logic trap,
    input logic mret,
    input logic jump,
    input logic [XLEN-1:0] jump_tgt,
    input logic is_call,
    input logic is_ret,
    input logic branch_taken,
    input logic [XLEN-1:0] branch_tgt,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    output logic [XLEN-1:0] epc,
    output logic misalign,
    output logic [RAS_CW-1:0] ras_count
);
    localparam int PW = $clog2(RAS_DEPTH);

    logic [XLEN-1:0] ras [RAS_DEPTH];
    logic [PW-1:0] top, top_next, wr_idx;
    logic [XLEN-1:0] seq_pc, tgt, epc_next;
    logic use_ras, redirect, bad_tgt, do_push, do_pop;
    logic [RAS_CW-1:0] cnt_pop, count_next;

    assign seq_pc = pc + XLEN'(4);
    assign use_ras = is_ret && ras_count != '0;
    assign redirect = !trap && !mret && (jump || branch_taken);
    assign tgt = jump ? (use_ras ? ras[top] : jump_tgt) : branch_tgt;
    assign bad_tgt = redirect && tgt[1:0] != 2'b00;
    assign do_pop = redirect && jump && use_ras && !bad_tgt;
    assign do_push = redirect && jump && is_call && !bad_tgt;

    always_comb begin
        pc_next = trap ? TRAP_VEC : mret ? epc : bad_tgt ? TRAP_VEC : redirect ? tgt : seq_pc;
        epc_next = trap ? pc : bad_tgt ? tgt : epc;
    end

    // A push after a pop lands in the slot just popped; at full it overwrites the oldest slot.
    assign cnt_pop = ras_count - RAS_CW'(do_pop);
    assign count_next = (do_push && cnt_pop != RAS_CW'(RAS_DEPTH)) ? cnt_pop + RAS_CW'(1) : cnt_pop;
    assign wr_idx = top - PW'(do_pop) + PW'(1);
    assign top_next = top - PW'(do_pop) + PW'(do_push);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_VEC;
            epc <= '0;
            misalign <= 1'b0;
            ras_count <= '0;
            top <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
        end else begin
            misalign <= pc_en && bad_tgt;
            if (pc_en) begin
                pc <= pc_next;
                epc <= epc_next;
                ras_count <= count_next;
                top <= top_next;
                if (do_push) ras[wr_idx] <= seq_pc;
            end
        end
    end
endmodule

// File: tb/tb_pc_gen_ras.sv
// tb_pc_gen_ras: directed spec scenarios plus randomized run against a queue-based reference model
module tb_pc_gen_ras;
    localparam logic [31:0] RV = 32'h0;
    localparam logic [31:0] TV = 32'h100;
    localparam int D = 4;

    logic clk = 0, reset = 1, pc_en = 0, trap = 0, mret = 0, jump = 0, is_call = 0, is_ret = 0, branch_taken = 0;
    logic [31:0] jump_tgt = 0, branch_tgt = 0, pc, pc_next, epc;
    logic misalign;
    logic [2:0] ras_count;
    int total = 0, bad = 0;
    logic [31:0] m_pc, m_epc, obs_next, exp_next;
    bit m_mis;
    logic [31:0] m_ras[$];

    pc_gen_ras dut (.clk(clk), .reset(reset), .pc_en(pc_en), .trap(trap), .mret(mret), .jump(jump),
        .jump_tgt(jump_tgt), .is_call(is_call), .is_ret(is_ret), .branch_taken(branch_taken),
        .branch_tgt(branch_tgt), .pc(pc), .pc_next(pc_next), .epc(epc), .misalign(misalign),
        .ras_count(ras_count));

    always #5 clk = ~clk;

    task automatic model(input bit en, tr, mr, jp, cl, rt, br, input logic [31:0] jt, bt);
        logic [31:0] t, np, ne;
        bit mis, ur, pop, push;
        ur = jp && rt && m_ras.size() > 0;
        t = jp ? (ur ? m_ras[$] : jt) : bt;
        mis = 0; pop = 0; push = 0; ne = m_epc;
        if (tr) begin np = TV; ne = m_pc; end
        else if (mr) np = m_epc;
        else if (jp || br) begin
            if (t[1:0] != 0) begin np = TV; ne = t; mis = 1; end
            else begin np = t; pop = ur; push = jp && cl; end
        end else np = m_pc + 4;
        exp_next = np;
        if (en) begin
            if (pop) void'(m_ras.pop_back());
            if (push) begin
                if (m_ras.size() == D) void'(m_ras.pop_front());
                m_ras.push_back(m_pc + 4);
            end
            m_pc = np; m_epc = ne;
        end
        m_mis = en && mis;
    endtask

    task automatic step(input bit en, tr, mr, jp, cl, rt, br, input logic [31:0] jt, bt);
        pc_en = en; trap = tr; mret = mr; jump = jp; is_call = cl; is_ret = rt; branch_taken = br;
        jump_tgt = jt; branch_tgt = bt;
        #1 obs_next = pc_next;
        model(en, tr, mr, jp, cl, rt, br, jt, bt);
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        {pc_en, trap, mret, jump, is_call, is_ret, branch_taken} = '0;
        reset = 1;
        m_pc = RV; m_epc = 0; m_mis = 0; m_ras.delete();
        @(posedge clk); #1 reset = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        do_reset();
        total++; if (pc !== RV) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, RV); end
        total++; if (epc !== 0) begin bad++; $display("FAIL reset_epc got=%h exp=0", epc); end
        total++; if (misalign !== 0) begin bad++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
        total++; if (ras_count !== 0) begin bad++; $display("FAIL reset_count got=%0d exp=0", ras_count); end
    endtask

    task automatic test_seq_stall;
        for (int i = 1; i <= 3; i++) begin
            step(1, 0, 0, 0, 0, 0, 0, 0, 0);
            total++; if (pc !== 32'(4 * i)) begin bad++; $display("FAIL seq_pc%0d got=%h exp=%h", i, pc, 32'(4 * i)); end
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 0);
            total++; if (pc !== 32'hC) begin bad++; $display("FAIL stall_pc got=%h exp=c", pc); end
            total++; if (obs_next !== 32'h10) begin bad++; $display("FAIL stall_pc_next got=%h exp=10", obs_next); end
        end
    endtask

    task automatic test_call_ret;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        total++; if (pc !== 32'h10) begin bad++; $display("FAIL pre_call_pc got=%h exp=10", pc); end
        step(1, 0, 0, 1, 1, 0, 0, 32'h200, 0);
        total++; if (pc !== 32'h200) begin bad++; $display("FAIL call_pc got=%h exp=200", pc); end
        total++; if (ras_count !== 1) begin bad++; $display("FAIL call_count got=%0d exp=1", ras_count); end
        step(1, 0, 0, 1, 0, 1, 0, 32'h999, 0);
        total++; if (pc !== 32'h14) begin bad++; $display("FAIL ret_pc got=%h exp=14", pc); end
        total++; if (ras_count !== 0) begin bad++; $display("FAIL ret_count got=%0d exp=0", ras_count); end
    endtask

    task automatic test_ras_overflow;
        logic [31:0] want;
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 1, 0, 0, 32'(32'h1000 * (i + 1)), 0);
        total++; if (ras_count !== 3'(D)) begin bad++; $display("FAIL full_count got=%0d exp=%0d", ras_count, D); end
        for (int i = 0; i < 5; i++) begin
            want = (i == 4) ? 32'h8000 : 32'(32'h1000 * (4 - i) + 4);
            step(1, 0, 0, 1, 0, 1, 0, 32'h8000, 0);
            total++; if (pc !== want) begin bad++; $display("FAIL ret%0d_pc got=%h exp=%h", i, pc, want); end
            total++; if (ras_count !== 3'(m_ras.size())) begin bad++; $display("FAIL ret%0d_count got=%0d exp=%0d", i, ras_count, m_ras.size()); end
        end
    endtask

    task automatic test_trap_mret;
        step(1, 0, 0, 1, 0, 0, 0, 32'h40, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        total++; if (pc !== TV) begin bad++; $display("FAIL trap_pc got=%h exp=%h", pc, TV); end
        total++; if (epc !== 32'h40) begin bad++; $display("FAIL trap_epc got=%h exp=40", epc); end
        step(1, 0, 1, 0, 0, 0, 0, 0, 0);
        total++; if (pc !== 32'h40) begin bad++; $display("FAIL mret_pc got=%h exp=40", pc); end
        step(1, 1, 0, 1, 1, 0, 0, 32'h500, 0);
        total++; if (pc !== TV) begin bad++; $display("FAIL trapjump_pc got=%h exp=%h", pc, TV); end
        total++; if (ras_count !== 0) begin bad++; $display("FAIL trapjump_count got=%0d exp=0", ras_count); end
    endtask

    task automatic test_misalign;
        step(1, 0, 0, 1, 1, 0, 0, 32'h300, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0, 32'h202);
        total++; if (pc !== TV) begin bad++; $display("FAIL mis_pc got=%h exp=%h", pc, TV); end
        total++; if (epc !== 32'h202) begin bad++; $display("FAIL mis_epc got=%h exp=202", epc); end
        total++; if (misalign !== 1) begin bad++; $display("FAIL mis_flag got=%b exp=1", misalign); end
        total++; if (ras_count !== 1) begin bad++; $display("FAIL mis_count got=%0d exp=1", ras_count); end
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        total++; if (misalign !== 0) begin bad++; $display("FAIL mis_pulse got=%b exp=0", misalign); end
        total++; if (pc !== 32'h104) begin bad++; $display("FAIL mis_after_pc got=%h exp=104", pc); end
    endtask

    task automatic test_wrap;
        step(1, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=0", pc); end
    endtask

    task automatic test_reset_mid;
        step(1, 0, 0, 1, 1, 0, 0, 32'h600, 0);
        step(1, 0, 0, 1, 1, 0, 0, 32'h700, 0);
        reset = 1;
        #1;
        total++; if (pc !== RV) begin bad++; $display("FAIL midreset_pc got=%h exp=%h", pc, RV); end
        total++; if (ras_count !== 0) begin bad++; $display("FAIL midreset_count got=%0d exp=0", ras_count); end
        do_reset();
    endtask

    task automatic test_random;
        logic [31:0] jt, bt;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 127) == 0) do_reset();
            jt = {$urandom_range(0, 1) ? 30'($urandom_range(0, 63)) : 30'($urandom), 2'b00};
            bt = {30'($urandom_range(0, 1023)), 2'b00};
            if ($urandom_range(0, 9) == 0) jt[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) bt[1:0] = 2'($urandom_range(1, 3));
            step($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) == 0, jt, bt);
            total++; if (obs_next !== exp_next) begin bad++; $display("FAIL rnd%0d_pc_next got=%h exp=%h", n, obs_next, exp_next); end
            total++; if (pc !== m_pc) begin bad++; $display("FAIL rnd%0d_pc got=%h exp=%h", n, pc, m_pc); end
            total++; if (epc !== m_epc) begin bad++; $display("FAIL rnd%0d_epc got=%h exp=%h", n, epc, m_epc); end
            total++; if (misalign !== m_mis) begin bad++; $display("FAIL rnd%0d_misalign got=%b exp=%b", n, misalign, m_mis); end
            total++; if (ras_count !== 3'(m_ras.size())) begin bad++; $display("FAIL rnd%0d_count got=%0d exp=%0d", n, ras_count, m_ras.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_seq_stall();
        test_call_ret();
        test_ras_overflow();
        test_trap_mret();
        test_misalign();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
